// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, fixed Config value
// and the {reg,sel} address helpers used by the parametrised register file.
package cp0_pkg;

  localparam logic [4:0] CR_INDEX    = 5'd0;
  localparam logic [4:0] CR_RANDOM   = 5'd1;
  localparam logic [4:0] CR_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CR_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CR_WIRED    = 5'd6;
  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_ENTRYHI  = 5'd10;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;
  localparam logic [4:0] CR_PRID     = 5'd15;
  localparam logic [4:0] CR_CONFIG   = 5'd16;

  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_MOD  = 5'd1;
  localparam logic [4:0] EX_TLBL = 5'd2;
  localparam logic [4:0] EX_TLBS = 5'd3;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;
  localparam logic [4:0] EX_SYS  = 5'd8;
  localparam logic [4:0] EX_BP   = 5'd9;
  localparam logic [4:0] EX_RI   = 5'd10;
  localparam logic [4:0] EX_OV   = 5'd12;

  // M=1, MT=TLB, K0=3 (cacheable)
  localparam logic [31:0] CONFIG0_VAL = 32'h8000_0083;

  function automatic logic [7:0] c0_addr(input logic [4:0] r, input logic [2:0] s);
    return {r, s};
  endfunction

  function automatic logic is_badvaddr_exc(input logic [4:0] code);
    return (code >= EX_MOD) && (code <= EX_ADES);
  endfunction

  function automatic logic is_tlb_exc(input logic [4:0] code);
    return (code >= EX_MOD) && (code <= EX_TLBS);
  endfunction

endpackage

// File: rtl/cp0_random_wired.sv
// Random/Wired pair: Random walks down from TLBNUM-1 to Wired, then wraps back;
// a Wired write restarts the walk from the top.
module cp0_random_wired
  import cp0_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wired_we_i,
  input  logic [IDXW-1:0] wired_wdata_i,
  output logic [IDXW-1:0] random_o,
  output logic [IDXW-1:0] wired_o
);

  localparam logic [IDXW-1:0] TOP = IDXW'(TLBNUM - 1);

  logic [IDXW-1:0] random_q, random_d;
  logic [IDXW-1:0] wired_q, wired_d;

  always_comb begin
    wired_d  = wired_q;
    random_d = random_q - 1'b1;
    if (wired_we_i) begin
      wired_d  = wired_wdata_i;
      random_d = TOP;
    end else if ((wired_q >= TOP) || (random_q <= wired_q)) begin
      // Reload one cycle after reaching Wired; a full Wired pins Random at the top.
      random_d = TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      random_q <= TOP;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random_o = random_q;
  assign wired_o  = wired_q;

endmodule

// File: rtl/cp0_regfile_param.sv
// Parametrised CP0 register file beside WB: exceptions, eret, mtc0/mfc0, TLB op results,
// Count/Compare timer. Define CP0_CONFIG_EN to expose read-only Config (16,0) and Config1 (16,1).
module cp0_regfile_param
  import cp0_pkg::*;
#(
  parameter int          TLBNUM    = 16,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4220,
  localparam int         IDXW      = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mtc0_we,
  input  logic [7:0]      c0_raddr,
  input  logic [31:0]     c0_wdata,
  input  logic            wb_ex,
  input  logic            wb_bd,
  input  logic [4:0]      wb_excode,
  input  logic [31:0]     wb_pc,
  input  logic [31:0]     wb_badvaddr,
  input  logic            eret_flush,
  input  logic [5:0]      ext_int_in,
  input  logic            tlbp,
  input  logic            tlbp_found,
  input  logic [IDXW-1:0] tlbp_index,
  input  logic            tlbr,
  input  logic [31:0]     r_entryhi,
  input  logic [31:0]     r_entrylo0,
  input  logic [31:0]     r_entrylo1,
  output logic [31:0]     rdata,
  output logic [31:0]     c0_epc,
  output logic            has_int,
  output logic [31:0]     c0_entryhi,
  output logic [31:0]     c0_entrylo0,
  output logic [31:0]     c0_entrylo1,
  output logic [31:0]     c0_index,
  output logic [IDXW-1:0] c0_random
);

  localparam int              PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(COUNT_DIV - 1);

  logic            we_index, we_lo0, we_lo1, we_wired, we_count;
  logic            we_ehi, we_compare, we_status, we_cause, we_epc;

  assign we_index   = mtc0_we && (c0_raddr == c0_addr(CR_INDEX, 3'd0));
  assign we_lo0     = mtc0_we && (c0_raddr == c0_addr(CR_ENTRYLO0, 3'd0));
  assign we_lo1     = mtc0_we && (c0_raddr == c0_addr(CR_ENTRYLO1, 3'd0));
  assign we_wired   = mtc0_we && (c0_raddr == c0_addr(CR_WIRED, 3'd0));
  assign we_count   = mtc0_we && (c0_raddr == c0_addr(CR_COUNT, 3'd0));
  assign we_ehi     = mtc0_we && (c0_raddr == c0_addr(CR_ENTRYHI, 3'd0));
  assign we_compare = mtc0_we && (c0_raddr == c0_addr(CR_COMPARE, 3'd0));
  assign we_status  = mtc0_we && (c0_raddr == c0_addr(CR_STATUS, 3'd0));
  assign we_cause   = mtc0_we && (c0_raddr == c0_addr(CR_CAUSE, 3'd0));
  assign we_epc     = mtc0_we && (c0_raddr == c0_addr(CR_EPC, 3'd0));

  logic            index_p_q, index_p_d;
  logic [IDXW-1:0] index_q, index_d;
  logic [18:0]     vpn2_q, vpn2_d;
  logic [7:0]      asid_q, asid_d;
  logic [25:0]     lo0_q, lo0_d, lo1_q, lo1_d;
  logic [31:0]     badvaddr_q, badvaddr_d;
  logic [31:0]     count_q, count_d, compare_q, compare_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic [7:0]      im_q, im_d;
  logic            exl_q, exl_d, ie_q, ie_d;
  logic            bd_q, bd_d, ti_q, ti_d;
  logic [5:0]      iphw_q, iphw_d;
  logic [1:0]      ipsw_q, ipsw_d;
  logic [4:0]      exc_q, exc_d;
  logic [31:0]     epc_q, epc_d;
  logic [IDXW-1:0] wired;
  logic            tlbr_g;

  assign tlbr_g = r_entrylo0[0] & r_entrylo1[0];

  cp0_random_wired #(.TLBNUM(TLBNUM)) u_random_wired (
    .clk           (clk),
    .reset         (reset),
    .wired_we_i    (we_wired),
    .wired_wdata_i (c0_wdata[IDXW-1:0]),
    .random_o      (c0_random),
    .wired_o       (wired)
  );

  // Sources are applied lowest priority first so later ones win on shared fields.
  always_comb begin
    index_p_d  = index_p_q;
    index_d    = index_q;
    vpn2_d     = vpn2_q;
    asid_d     = asid_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ipsw_d     = ipsw_q;
    exc_d      = exc_q;
    epc_d      = epc_q;

    if (we_status) begin
      im_d  = c0_wdata[15:8];
      exl_d = c0_wdata[1];
      ie_d  = c0_wdata[0];
    end
    if (we_cause)   ipsw_d    = c0_wdata[9:8];
    if (we_epc)     epc_d     = c0_wdata;
    if (we_index)   index_d   = c0_wdata[IDXW-1:0];
    if (we_lo0)     lo0_d     = c0_wdata[25:0];
    if (we_lo1)     lo1_d     = c0_wdata[25:0];
    if (we_compare) compare_d = c0_wdata;
    if (we_ehi) begin
      vpn2_d = c0_wdata[31:13];
      asid_d = c0_wdata[7:0];
    end

    if (we_count) begin
      count_d = c0_wdata;
      presc_d = '0;
      tick_d  = 1'b0;
    end else if (presc_q == PRESC_MAX) begin
      count_d = count_q + 32'd1;
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      count_d = count_q;
      presc_d = presc_q + 1'b1;
      tick_d  = 1'b0;
    end

    // Only a freshly incremented Count may match, so Count=Compare=0 after reset stays quiet.
    ti_d = ti_q;
    if (we_compare)                          ti_d = 1'b0;
    else if (tick_q && count_q == compare_q) ti_d = 1'b1;
    iphw_d = {ext_int_in[5] | ti_q, ext_int_in[4:0]};

    if (tlbp) begin
      index_p_d = ~tlbp_found;
      if (tlbp_found) index_d = tlbp_index;
    end
    if (tlbr) begin
      vpn2_d = r_entryhi[31:13];
      asid_d = r_entryhi[7:0];
      lo0_d  = {r_entrylo0[25:1], tlbr_g};
      lo1_d  = {r_entrylo1[25:1], tlbr_g};
    end

    if (eret_flush) exl_d = 1'b0;

    if (wb_ex) begin
      exl_d = 1'b1;
      exc_d = wb_excode;
      if (!exl_q) begin
        bd_d  = wb_bd;
        epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
      end
      if (is_badvaddr_exc(wb_excode)) badvaddr_d = wb_badvaddr;
      if (is_tlb_exc(wb_excode))      vpn2_d     = wb_badvaddr[31:13];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_p_q  <= 1'b0;
      index_q    <= '0;
      vpn2_q     <= '0;
      asid_q     <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      iphw_q     <= '0;
      ipsw_q     <= '0;
      exc_q      <= '0;
      epc_q      <= '0;
    end else begin
      index_p_q  <= index_p_d;
      index_q    <= index_d;
      vpn2_q     <= vpn2_d;
      asid_q     <= asid_d;
      lo0_q      <= lo0_d;
      lo1_q      <= lo1_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      iphw_q     <= iphw_d;
      ipsw_q     <= ipsw_d;
      exc_q      <= exc_d;
      epc_q      <= epc_d;
    end
  end

  logic [31:0] status_val, cause_val;
  assign status_val  = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val   = {bd_q, ti_q, 14'b0, iphw_q, ipsw_q, 1'b0, exc_q, 2'b0};

  assign c0_epc      = epc_q;
  assign c0_entryhi  = {vpn2_q, 5'b0, asid_q};
  assign c0_entrylo0 = {6'b0, lo0_q};
  assign c0_entrylo1 = {6'b0, lo1_q};
  assign c0_index    = {index_p_q, {(31 - IDXW){1'b0}}, index_q};
  assign has_int     = (|({iphw_q, ipsw_q} & im_q)) & ie_q & ~exl_q;

  always_comb begin
    rdata = '0;
    case (c0_raddr)
      c0_addr(CR_INDEX, 3'd0):    rdata = c0_index;
      c0_addr(CR_RANDOM, 3'd0):   rdata = {{(32 - IDXW){1'b0}}, c0_random};
      c0_addr(CR_ENTRYLO0, 3'd0): rdata = c0_entrylo0;
      c0_addr(CR_ENTRYLO1, 3'd0): rdata = c0_entrylo1;
      c0_addr(CR_WIRED, 3'd0):    rdata = {{(32 - IDXW){1'b0}}, wired};
      c0_addr(CR_BADVADDR, 3'd0): rdata = badvaddr_q;
      c0_addr(CR_COUNT, 3'd0):    rdata = count_q;
      c0_addr(CR_ENTRYHI, 3'd0):  rdata = c0_entryhi;
      c0_addr(CR_COMPARE, 3'd0):  rdata = compare_q;
      c0_addr(CR_STATUS, 3'd0):   rdata = status_val;
      c0_addr(CR_CAUSE, 3'd0):    rdata = cause_val;
      c0_addr(CR_EPC, 3'd0):      rdata = epc_q;
      c0_addr(CR_PRID, 3'd0):     rdata = PRID_VAL;
`ifdef CP0_CONFIG_EN
      c0_addr(CR_CONFIG, 3'd0):   rdata = CONFIG0_VAL;
      c0_addr(CR_CONFIG, 3'd1):   rdata = {1'b0, 6'(TLBNUM - 1), 25'b0};
`else
`endif
      default:                    rdata = '0;
    endcase
  end

  logic unused_tlbr_bits;
  assign unused_tlbr_bits = ^{r_entryhi[12:8], r_entrylo0[31:26], r_entrylo1[31:26]};

endmodule

// File: tb/tb_cp0_regfile_param.sv
// Self-checking bench for cp0_regfile_param: directed steps from the test plan, then random
// commits checked every cycle against a register-image reference model.
module tb_cp0_regfile_param;

  localparam int TLBNUM = 16;
  localparam int COUNT_DIV = 2;
  localparam logic [31:0] PRID = 32'h0000_4220;
`ifdef CP0_CONFIG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mtc0_we = 1'b0;
  logic [7:0]  c0_raddr = '0;
  logic [31:0] c0_wdata = '0;
  logic        wb_ex = 1'b0, wb_bd = 1'b0;
  logic [4:0]  wb_excode = '0;
  logic [31:0] wb_pc = '0, wb_badvaddr = '0;
  logic        eret_flush = 1'b0;
  logic [5:0]  ext_int_in = '0;
  logic        tlbp = 1'b0, tlbp_found = 1'b0, tlbr = 1'b0;
  logic [3:0]  tlbp_index = '0;
  logic [4:0]  tlbp_index32;
  logic [31:0] r_entryhi = '0, r_entrylo0 = '0, r_entrylo1 = '0;
  logic [31:0] rdata, c0_epc, c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index;
  logic        has_int;
  logic [3:0]  c0_random;
  logic [31:0] rdata32, unused_epc32, unused_ehi32, unused_lo032, unused_lo132, unused_idx32;
  logic        unused_int32;
  logic [4:0]  c0_random32;

  assign tlbp_index32 = {1'b0, tlbp_index};

  always #5 clk = ~clk;

  cp0_regfile_param #(.TLBNUM(TLBNUM), .COUNT_DIV(COUNT_DIV), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .c0_raddr(c0_raddr), .c0_wdata(c0_wdata),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .ext_int_in(ext_int_in),
    .tlbp(tlbp), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index), .tlbr(tlbr),
    .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
    .rdata(rdata), .c0_epc(c0_epc), .has_int(has_int), .c0_entryhi(c0_entryhi),
    .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1), .c0_index(c0_index),
    .c0_random(c0_random)
  );

  cp0_regfile_param #(.TLBNUM(32), .COUNT_DIV(1), .PRID_VAL(PRID)) dut32 (
    .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .c0_raddr(c0_raddr), .c0_wdata(c0_wdata),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .ext_int_in(ext_int_in),
    .tlbp(tlbp), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index32), .tlbr(tlbr),
    .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
    .rdata(rdata32), .c0_epc(unused_epc32), .has_int(unused_int32),
    .c0_entryhi(unused_ehi32), .c0_entrylo0(unused_lo032), .c0_entrylo1(unused_lo132),
    .c0_index(unused_idx32), .c0_random(c0_random32)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: architectural register images indexed by CP0 register number (sel 0).
  logic [31:0] m_img [0:31];
  logic [31:0] n_img [0:31];
  int          m_random, n_random, m_presc, n_presc;
  bit          m_tick, n_tick;

  function automatic logic [7:0] ra(input int r, input int s);
    return {5'(r), 3'(s)};
  endfunction

  function automatic logic [31:0] wmask(input int r);
    case (r)
      0, 6:       return 32'(TLBNUM - 1);
      2, 3:       return 32'h03FF_FFFF;
      9, 11, 14:  return 32'hFFFF_FFFF;
      10:         return 32'hFFFF_E0FF;
      12:         return 32'h0000_FF03;
      13:         return 32'h0000_0300;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int r;
    r = int'(a[7:3]);
    if (a == ra(16, 1)) return CFG_EN ? 32'((TLBNUM - 1) << 25) : 32'h0;
    if (a[2:0] != 3'd0) return 32'h0;
    case (r)
      0, 2, 3, 6, 8, 9, 10, 11, 12, 13, 14: return m_img[r];
      1:       return 32'(m_random);
      15:      return PRID;
      16:      return CFG_EN ? 32'h8000_0083 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    return ((m_img[13][15:8] & m_img[12][15:8]) != 8'h0) && m_img[12][0] && !m_img[12][1];
  endfunction

  task automatic model_next();
    int  r;
    bit  hit, wr_count, wr_cmp, wr_wired;
    logic g;
    n_img = m_img;
    if (reset) begin
      for (int i = 0; i < 32; i++) n_img[i] = 32'h0;
      n_img[12] = 32'h0040_0000;
      n_random = TLBNUM - 1;
      n_presc = 0;
      n_tick = 1'b0;
      return;
    end
    r = int'(c0_raddr[7:3]);
    wr_count = mtc0_we && c0_raddr == ra(9, 0);
    wr_cmp   = mtc0_we && c0_raddr == ra(11, 0);
    wr_wired = mtc0_we && c0_raddr == ra(6, 0);
    hit = m_tick && (m_img[9] == m_img[11]);
    if (mtc0_we && c0_raddr[2:0] == 3'd0)
      n_img[r] = (m_img[r] & ~wmask(r)) | (c0_wdata & wmask(r));
    if (wr_count) begin
      n_presc = 0; n_tick = 1'b0;
    end else if (m_presc == COUNT_DIV - 1) begin
      n_img[9] = m_img[9] + 32'd1; n_presc = 0; n_tick = 1'b1;
    end else begin
      n_presc = m_presc + 1; n_tick = 1'b0;
    end
    if (wr_cmp) n_img[13][30] = 1'b0;
    else if (hit) n_img[13][30] = 1'b1;
    n_img[13][15:10] = {ext_int_in[5] | m_img[13][30], ext_int_in[4:0]};
    if (wr_wired || m_img[6] >= 32'(TLBNUM - 1) || 32'(m_random) == m_img[6])
      n_random = TLBNUM - 1;
    else
      n_random = m_random - 1;
    if (tlbp) begin
      if (tlbp_found) n_img[0] = 32'(tlbp_index);
      else n_img[0][31] = 1'b1;
    end
    if (tlbr) begin
      g = r_entrylo0[0] & r_entrylo1[0];
      n_img[10] = r_entryhi & 32'hFFFF_E0FF;
      n_img[2] = {6'b0, r_entrylo0[25:1], g};
      n_img[3] = {6'b0, r_entrylo1[25:1], g};
    end
    if (eret_flush) n_img[12][1] = 1'b0;
    if (wb_ex) begin
      if (!m_img[12][1]) begin
        n_img[14] = wb_bd ? wb_pc - 32'd4 : wb_pc;
        n_img[13][31] = wb_bd;
      end
      n_img[12][1] = 1'b1;
      n_img[13][6:2] = wb_excode;
      if (wb_excode >= 5'd1 && wb_excode <= 5'd5) n_img[8] = wb_badvaddr;
      if (wb_excode >= 5'd1 && wb_excode <= 5'd3) n_img[10][31:13] = wb_badvaddr[31:13];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: model and DUT advance together, then every visible output is compared.
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_img = n_img;
    m_random = n_random;
    m_presc = n_presc;
    m_tick = n_tick;
    chk("rdata", rdata, m_read(c0_raddr));
    chk("epc", c0_epc, m_img[14]);
    chk("has_int", {31'b0, has_int}, {31'b0, m_has_int()});
    chk("entryhi", c0_entryhi, m_img[10]);
    chk("entrylo0", c0_entrylo0, m_img[2]);
    chk("entrylo1", c0_entrylo1, m_img[3]);
    chk("index", c0_index, m_img[0]);
    chk("random", 32'(c0_random), 32'(m_random));
    mtc0_we = 1'b0; wb_ex = 1'b0; eret_flush = 1'b0; tlbp = 1'b0; tlbr = 1'b0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; c0_raddr = a; c0_wdata = d;
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    c0_raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic exc(input logic bd, input logic [31:0] pc, input logic [4:0] code,
                     input logic [31:0] bad);
    wb_ex = 1'b1; wb_bd = bd; wb_pc = pc; wb_excode = code; wb_badvaddr = bad;
    step();
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 17))
      0: return ra(0, 0);   1: return ra(1, 0);   2: return ra(2, 0);
      3: return ra(3, 0);   4: return ra(6, 0);   5: return ra(8, 0);
      6: return ra(9, 0);   7: return ra(10, 0);  8: return ra(11, 0);
      9: return ra(12, 0);  10: return ra(13, 0); 11: return ra(14, 0);
      12: return ra(15, 0); 13: return ra(16, 0); 14: return ra(16, 1);
      15: return ra(12, 1); 16: return ra(4, 0);
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] rnd_exp [4];
    logic [31:0] v;
    rnd_exp = '{32'd14, 32'd13, 32'd12, 32'd15};

    // Reset state
    repeat (3) step();
    chk("rand32_rst", 32'(c0_random32), 32'd31);
    reset = 1'b0;
    rd_chk("rst_status", ra(12, 0), 32'h0040_0000);
    rd_chk("rst_cause", ra(13, 0), 32'h0);
    rd_chk("rst_count", ra(9, 0), 32'h0);
    rd_chk("rst_random", ra(1, 0), 32'd15);
    c0_raddr = ra(13, 0);
    repeat (20) step();
    chk("ti_quiet", {31'b0, rdata[30]}, 32'h0);

    // Count / Compare / timer interrupt
    mtc0(ra(12, 0), 32'h0000_8001);
    mtc0(ra(11, 0), 32'd8);
    mtc0(ra(9, 0), 32'd5);
    c0_raddr = ra(9, 0);
    repeat (6) step();
    chk("count_8", rdata, 32'd8);
    rd_chk("ti_not_yet", ra(13, 0), 32'h0);
    step();
    chk("ti_set", rdata, 32'h4000_0000);
    chk("int_lag", {31'b0, has_int}, 32'h0);
    step();
    chk("ip7_set", rdata, 32'h4000_8000);
    chk("has_int", {31'b0, has_int}, 32'h1);
    mtc0(ra(11, 0), 32'd1000);
    rd_chk("ti_clr", ra(13, 0), 32'h0000_8000);
    step();
    chk("ip7_clr", rdata, 32'h0);

    // Random / Wired
    mtc0(ra(6, 0), 32'd12);
    chk("rnd_reload", 32'(c0_random), 32'd15);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rnd_seq", 32'(c0_random), rnd_exp[i]);
    end
    mtc0(ra(6, 0), 32'd15);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rnd_hold", 32'(c0_random), 32'd15);
    end
    mtc0(ra(6, 0), 32'd0);

    // Exceptions and eret
    exc(1'b1, 32'hBFC0_0104, 5'd3, 32'h1234_5678);
    chk("epc_bd", c0_epc, 32'hBFC0_0100);
    chk("vpn2", c0_entryhi, 32'h1234_4000);
    rd_chk("cause_bd_exc", ra(13, 0), 32'h8000_000C);
    rd_chk("status_exl", ra(12, 0), 32'h0040_8003);
    rd_chk("badvaddr", ra(8, 0), 32'h1234_5678);
    exc(1'b0, 32'h8000_0180, 5'd4, 32'hDEAD_BEEF);
    chk("epc_keep", c0_epc, 32'hBFC0_0100);
    chk("vpn2_keep", c0_entryhi, 32'h1234_4000);
    rd_chk("cause_keep_bd", ra(13, 0), 32'h8000_0010);
    eret_flush = 1'b1;
    c0_raddr = ra(12, 0);
    step();
    chk("eret_exl", rdata, 32'h0040_8001);

    // TLB ops
    tlbp = 1'b1; tlbp_found = 1'b0;
    step();
    chk("tlbp_miss", c0_index, 32'h8000_0000);
    tlbp = 1'b1; tlbp_found = 1'b1; tlbp_index = 4'd7;
    step();
    chk("tlbp_hit", c0_index, 32'h0000_0007);
    tlbr = 1'b1; r_entryhi = 32'hAAAA_A0BB; r_entrylo0 = 32'h0123_4567; r_entrylo1 = 32'h0765_4320;
    mtc0(ra(10, 0), 32'h5555_5011);
    chk("tlbr_wins", c0_entryhi, 32'hAAAA_A0BB);
    chk("tlbr_lo0", c0_entrylo0, 32'h0123_4566);
    chk("tlbr_lo1", c0_entrylo1, 32'h0365_4320);

    // Config / Config1
    rd_chk("config1", ra(16, 1), CFG_EN ? 32'h1E00_0000 : 32'h0);
    chk("config1_32", rdata32, CFG_EN ? 32'h3E00_0000 : 32'h0);
    rd_chk("config0", ra(16, 0), CFG_EN ? 32'h8000_0083 : 32'h0);
    rd_chk("prid", ra(15, 0), PRID);

    // Random commits against the model
    for (int i = 0; i < 800; i++) begin
      c0_raddr = pick_addr();
      mtc0_we = ($urandom_range(0, 2) == 0);
      v = $urandom;
      if (c0_raddr == ra(9, 0) || c0_raddr == ra(11, 0)) v = 32'($urandom_range(0, 30));
      if (c0_raddr == ra(6, 0)) v = 32'($urandom_range(0, 15));
      c0_wdata = v;
      wb_ex = ($urandom_range(0, 15) == 0);
      wb_bd = 1'($urandom);
      wb_excode = 5'($urandom_range(0, 12));
      wb_pc = $urandom;
      wb_badvaddr = $urandom;
      eret_flush = ($urandom_range(0, 15) == 0);
      ext_int_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      tlbp = ($urandom_range(0, 9) == 0);
      tlbp_found = 1'($urandom);
      tlbp_index = 4'($urandom);
      tlbr = ($urandom_range(0, 9) == 0);
      r_entryhi = $urandom; r_entrylo0 = $urandom; r_entrylo1 = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cp0_regfile_param.md
Name: cp0_regfile_param

Overview:
Parametrised CP0 register file for the MIPS-like pipelined core; successor to the fixed 16-entry CP0.
- Sits beside the WB stage: takes exception/eret/mtc0 commits and TLB op results, and supplies mfc0 read data, EPC, the interrupt request and TLB-facing registers.
- Adds TLB depth and Count prescaler parameters, Random/Wired registers, PRId, and edge-qualified timer interrupt (no spurious TI at reset).

Parameters:
TLBNUM, 16, TLB entry count (power of 2, 2..64); IDXW = log2(TLBNUM) derived locally
COUNT_DIV, 2, clk cycles per Count increment (>=1)
PRID_VAL, 32'h0000_4220, constant returned by PRId

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mtc0_we  in  1  mtc0 commit this cycle
c0_raddr  in  8  {reg[4:0], sel[2:0]}, used for both read and write
c0_wdata  in  32  mtc0 data
wb_ex  in  1  exception commit
wb_bd  in  1  excepting instr in delay slot
wb_excode  in  5  ExcCode
wb_pc  in  32  excepting PC
wb_badvaddr  in  32  faulting address
eret_flush  in  1  eret commit
ext_int_in  in  6  hardware interrupts, level
tlbp  in  1  tlbp commit
tlbp_found  in  1  tlbp hit
tlbp_index  in  IDXW  hit index
tlbr  in  1  tlbr commit
r_entryhi  in  32  tlbr result, EntryHi layout
r_entrylo0  in  32  tlbr result, EntryLo0 layout
r_entrylo1  in  32  tlbr result, EntryLo1 layout
rdata  out  32  mfc0 data, combinational
c0_epc  out  32  EPC
has_int  out  1  interrupt request
c0_entryhi  out  32  EntryHi
c0_entrylo0  out  32  EntryLo0
c0_entrylo1  out  32  EntryLo1
c0_index  out  32  Index
c0_random  out  IDXW  Random, for tlbwr

Behaviour:
- Decode uses the full 8 bits. Every register is sel 0 except Config1 (16,1). Unmapped reads return 0; unmapped writes are ignored.
- Same-cycle priority on any shared field: wb_ex > eret_flush > tlbr/tlbp > mtc0.
- Reset values: all outputs 0 except c0_random = TLBNUM-1. Status reads 0x0040_0000; BEV is hardwired 1.
- Status: IM[15:8] and IE[0] written by mtc0. EXL[1] set by wb_ex, cleared by eret_flush, else mtc0.
- Cause:
  - BD updated on wb_ex && !EXL.
  - IP[7:2] registered one cycle after input: IP7 = ext_int_in[5] | TI; IP[6:2] = ext_int_in[4:0].
  - IP[1:0] written by mtc0.
  - ExcCode[6:2] loaded on every wb_ex.
- EPC: on wb_ex && !EXL, loads wb_bd ? wb_pc-4 : wb_pc; otherwise loaded by mtc0.
- BadVAddr: loads wb_badvaddr on wb_ex with ExcCode in {Mod=1, TLBL=2, TLBS=3, AdEL=4, AdES=5}.
- Count:
  - Prescaler counts 0..COUNT_DIV-1; Count increments (wrapping at 2^32) in the cycle the prescaler equals COUNT_DIV-1.
  - mtc0 Count loads Count and clears the prescaler.
  - COUNT_DIV=1 means increment every cycle.
- Compare: mtc0 loads Compare and clears TI. TI sets in the cycle after Count increments to a value equal to Compare, so 0==0 after reset does not fire. A Compare write and a match in the same cycle leave TI = 0.
- Random:
  - Decrements every cycle; the cycle after it equals Wired it reloads TLBNUM-1.
  - If Wired >= TLBNUM-1 it holds TLBNUM-1.
  - mtc0 Wired resets Random to TLBNUM-1 on the next edge. Random is read-only.
- Wired: writes bits [IDXW-1:0]; upper bits read 0.
- Index:
  - P[31] set by tlbp && !tlbp_found, cleared by tlbp && tlbp_found; not writable.
  - Index[IDXW-1:0] loaded by mtc0 or by a tlbp hit.
- EntryHi[31:13,7:0]: mtc0 or tlbr loads. wb_ex with ExcCode 1/2/3 loads VPN2 = badvaddr[31:13] and leaves ASID unchanged.
- EntryLo0/1 [25:0]: mtc0 or tlbr loads; G is taken from r_entrylo0[0] & r_entrylo1[0] for both.
- PRId (15,0): reads PRID_VAL.
- has_int = |(Cause.IP & Status.IM) & IE & !EXL, combinational.

Optional Feature:
CP0_CONFIG_EN.
- Defined: Config (16,0) reads {1'b1, 15'b0, 1'b0, 2'b00, 3'b000, 3'b001, 4'b0, 3'b011}, i.e. M=1, MT=TLB, K0=3. Config1 (16,1) reads MMUSize[30:25] = TLBNUM-1, all other fields 0. Both are read-only.
- Undefined: both read 0 like unmapped registers; no other behaviour changes.

Decomposition:
- Shared package cp0_pkg: CR_* register numbers (INDEX 0, RANDOM 1, ENTRYLO0 2, ENTRYLO1 3, WIRED 6, BADVADDR 8, COUNT 9, ENTRYHI 10, COMPARE 11, STATUS 12, CAUSE 13, EPC 14, PRID 15, CONFIG 16), EX_* codes, and the {reg,sel} compose helper.
- Sub-module cp0_random_wired: holds the Random/Wired counter pair.

Test Plan:
- Reset, then read Status/Cause/Count/Random -> 0x0040_0000 / 0 / 0 / TLBNUM-1. TI stays 0 for 20 cycles with Compare=0.
- COUNT_DIV=2; mtc0 Count=5, Compare=8 -> Count reaches 8 after 6 cycles. TI/IP7 set the next cycle. has_int=1 with IM7=1, IE=1, EXL=0. mtc0 Compare clears TI.
- TLBNUM=16, mtc0 Wired=12 -> Random sequence 15,14,13,12,15. Wired=15 -> Random held at 15.
- wb_ex with wb_bd=1, pc=0xBFC0_0104, excode=TLBS -> EPC=0xBFC0_0100, BD=1, EXL=1, BadVAddr and VPN2 loaded. A second wb_ex while EXL=1 leaves EPC/BD unchanged. eret_flush -> EXL=0.
- tlbp miss -> Index=0x8000_0000. tlbp hit index 7 -> 0x0000_0007. tlbr + mtc0 EntryHi in the same cycle -> tlbr value wins.
- With CP0_CONFIG_EN, TLBNUM=32: read (16,1) -> MMUSize=31. Without the macro -> 0.
